// File: rtl/tone_sequencer_pkg.sv
// Shared types and constants for the tone sequencer and its note queue.
// Holds the FSM state encoding, field widths and the note-code clamp.
package tone_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_PLAY = 2'd2,
        ST_GAP  = 2'd3
    } state_t;

    localparam int MAX_NOTE = 52;
    localparam int NOTE_W   = 6;
    localparam int LEN_W    = 8;
    localparam int OUT_W    = 16;
    localparam int ENTRY_W  = NOTE_W + LEN_W;

    localparam logic [NOTE_W-1:0] MAX_NOTE_CODE = NOTE_W'(MAX_NOTE);

    // Codes beyond the pitch table are turned into rests.
    function automatic logic [NOTE_W-1:0] clamp_note(input logic [NOTE_W-1:0] code);
        if (code > MAX_NOTE_CODE) begin
            return {NOTE_W{1'b0}};
        end else begin
            return code;
        end
    endfunction

endpackage

// File: rtl/tone_fifo.sv
// Synchronous note queue with flush, registered full/empty flags and a fill level.
// The head entry is visible on rd_data without a read latency.
module tone_fifo
    import tone_sequencer_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int W     = ENTRY_W,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          CLK,
    input  logic          RSTN,
    input  logic          flush,
    input  logic          wr_en,
    input  logic [W-1:0]  wr_data,
    input  logic          rd_en,
    output logic [W-1:0]  rd_data,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   level
);

    logic [W-1:0]  mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [AW:0]   level_r;
    logic [AW:0]   level_next_s;
    logic          full_r;
    logic          empty_r;
    logic          wr_ok_s;
    logic          rd_ok_s;

    // A flush wins over both a push and a pop in the same cycle.
    assign wr_ok_s = wr_en & ~full_r & ~flush;
    assign rd_ok_s = rd_en & ~empty_r & ~flush;

    // Next fill level from the accepted push/pop pair.
    always_comb begin
        level_next_s = level_r;
        if (flush) begin
            level_next_s = {(AW+1){1'b0}};
        end else begin
            case ({wr_ok_s, rd_ok_s})
                2'b10:   level_next_s = level_r + {{AW{1'b0}}, 1'b1};
                2'b01:   level_next_s = level_r - {{AW{1'b0}}, 1'b1};
                default: level_next_s = level_r;
            endcase
        end
    end

    // Storage array; contents are qualified by the pointers so need no reset.
    always_ff @(posedge CLK) begin
        if (wr_ok_s) begin
            mem_r[wr_ptr_r] <= wr_data;
        end
    end

    // Pointers, level and flags.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            level_r  <= {(AW+1){1'b0}};
            full_r   <= 1'b0;
            empty_r  <= 1'b1;
        end else begin
            if (flush) begin
                wr_ptr_r <= {AW{1'b0}};
                rd_ptr_r <= {AW{1'b0}};
            end else begin
                if (wr_ok_s) wr_ptr_r <= wr_ptr_r + {{(AW-1){1'b0}}, 1'b1};
                if (rd_ok_s) rd_ptr_r <= rd_ptr_r + {{(AW-1){1'b0}}, 1'b1};
            end
            level_r <= level_next_s;
            full_r  <= (level_next_s == (AW+1)'(DEPTH));
            empty_r <= (level_next_s == {(AW+1){1'b0}});
        end
    end

    assign rd_data = mem_r[rd_ptr_r];
    assign full    = full_r;
    assign empty   = empty_r;
    assign level   = level_r;

endmodule

// File: rtl/tone_sequencer.sv
// Plays queued {note, length} entries as timed pitch codes with a silent gap after each.
// Durations are counted in ticks of TICK_DIV clock cycles.
module tone_sequencer
    import tone_sequencer_pkg::*;
#(
    parameter int DEPTH     = 8,
    parameter int TICK_DIV  = 20000,
    parameter int GAP_TICKS = 2
) (
    input  logic              CLK,
    input  logic              RSTN,
    input  logic              wr_en,
    input  logic [NOTE_W-1:0] wr_note,
    input  logic [LEN_W-1:0]  wr_len,
    input  logic              abort,
    output logic              full,
    output logic              empty,
    output logic [OUT_W-1:0]  note,
    output logic              busy,
    output logic              done
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int AW = $clog2(DEPTH);
    localparam logic [PW-1:0]    PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [LEN_W-1:0] GAP_LAST   = LEN_W'(GAP_TICKS - 1);
    localparam bit               HAS_GAP    = (GAP_TICKS > 0);

    state_t              state_r;
    state_t              state_next_s;
    logic [PW-1:0]       presc_r;
    logic [LEN_W-1:0]    tick_r;
    logic [LEN_W-1:0]    len_r;
    logic [NOTE_W-1:0]   pitch_r;
    logic [OUT_W-1:0]    note_r;
    logic                busy_r;
    logic                done_r;
    logic [OUT_W-1:0]    note_next_s;
    logic                busy_next_s;
    logic                done_next_s;
    logic [ENTRY_W-1:0]  head_s;
    logic [NOTE_W-1:0]   head_note_s;
    logic [LEN_W-1:0]    head_len_s;
    logic [AW:0]         level_s;
    logic                more_s;
    logic                tick_end_s;
    logic                play_end_s;
    logic                gap_end_s;

    tone_fifo #(
        .DEPTH (DEPTH),
        .W     (ENTRY_W)
    ) u_fifo (
        .CLK     (CLK),
        .RSTN    (RSTN),
        .flush   (abort),
        .wr_en   (wr_en),
        .wr_data ({clamp_note(wr_note), wr_len}),
        .rd_en   (state_r == ST_LOAD),
        .rd_data (head_s),
        .full    (full),
        .empty   (empty),
        .level   (level_s)
    );

    assign head_note_s = head_s[ENTRY_W-1 -: NOTE_W];
    assign head_len_s  = head_s[LEN_W-1:0];
    // In LOAD the head is being popped, so another entry exists only if more than one is queued.
    assign more_s      = (level_s > (AW+1)'(1));
    assign tick_end_s  = (presc_r == PRESC_LAST);
    assign play_end_s  = tick_end_s && (tick_r == (len_r - 8'd1));
    assign gap_end_s   = tick_end_s && (tick_r == GAP_LAST);

    // State register.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic; abort overrides every other event.
    always_comb begin
        state_next_s = state_r;
        if (abort) begin
            state_next_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: state_next_s = empty ? ST_IDLE : ST_LOAD;
                ST_LOAD: begin
                    if (head_len_s == {LEN_W{1'b0}}) begin
                        state_next_s = more_s ? ST_LOAD : ST_IDLE;
                    end else begin
                        state_next_s = ST_PLAY;
                    end
                end
                ST_PLAY: begin
                    if (!play_end_s) begin
                        state_next_s = ST_PLAY;
                    end else if (HAS_GAP) begin
                        state_next_s = ST_GAP;
                    end else begin
                        state_next_s = empty ? ST_IDLE : ST_LOAD;
                    end
                end
                ST_GAP: begin
                    if (gap_end_s) begin
                        state_next_s = empty ? ST_IDLE : ST_LOAD;
                    end else begin
                        state_next_s = ST_GAP;
                    end
                end
                default: state_next_s = ST_IDLE;
            endcase
        end
    end

    // Output decode from the upcoming state so the registered outputs change on entry.
    always_comb begin
        note_next_s = {OUT_W{1'b0}};
        busy_next_s = (state_next_s != ST_IDLE);
        done_next_s = 1'b0;
        if (state_next_s == ST_PLAY) begin
            note_next_s = {{(OUT_W-NOTE_W){1'b0}},
                           (state_r == ST_LOAD) ? head_note_s : pitch_r};
        end else begin
            note_next_s = {OUT_W{1'b0}};
        end
        if (!abort && (state_next_s == ST_IDLE) &&
            ((state_r == ST_PLAY) || (state_r == ST_GAP))) begin
            done_next_s = 1'b1;
        end else begin
            done_next_s = 1'b0;
        end
    end

    // Output registers and the entry latched during LOAD.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            note_r  <= {OUT_W{1'b0}};
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            pitch_r <= {NOTE_W{1'b0}};
            len_r   <= {LEN_W{1'b0}};
        end else begin
            note_r <= note_next_s;
            busy_r <= busy_next_s;
            done_r <= done_next_s;
            if (state_r == ST_LOAD) begin
                pitch_r <= head_note_s;
                len_r   <= head_len_s;
            end
        end
    end

    // Prescaler and tick counter; held clear outside PLAY/GAP and on every state change.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            presc_r <= {PW{1'b0}};
            tick_r  <= {LEN_W{1'b0}};
        end else if ((state_next_s != state_r) || (state_r == ST_IDLE) ||
                     (state_r == ST_LOAD)) begin
            presc_r <= {PW{1'b0}};
            tick_r  <= {LEN_W{1'b0}};
        end else if (tick_end_s) begin
            presc_r <= {PW{1'b0}};
            tick_r  <= tick_r + 8'd1;
        end else begin
            presc_r <= presc_r + {{(PW-1){1'b0}}, 1'b1};
        end
    end

    assign note = note_r;
    assign busy = busy_r;
    assign done = done_r;

endmodule

// File: tb/tb_tone_sequencer.sv
// Directed bench for tone_sequencer with TICK_DIV=4 and GAP_TICKS=1:
// a one-tick note lasts 4 cycles and is followed by 4 silent cycles.
module tb_tone_sequencer;

    logic        CLK = 1'b0;
    logic        RSTN = 1'b0;
    logic        wr_en = 1'b0;
    logic [5:0]  wr_note = 6'd0;
    logic [7:0]  wr_len = 8'd0;
    logic        abort = 1'b0;
    logic        full;
    logic        empty;
    logic [15:0] note;
    logic        busy;
    logic        done;

    int tests = 0;
    int failed = 0;
    int done_cnt = 0;
    int d0;

    tone_sequencer #(.DEPTH(8), .TICK_DIV(4), .GAP_TICKS(1)) dut (
        .CLK     (CLK),
        .RSTN    (RSTN),
        .wr_en   (wr_en),
        .wr_note (wr_note),
        .wr_len  (wr_len),
        .abort   (abort),
        .full    (full),
        .empty   (empty),
        .note    (note),
        .busy    (busy),
        .done    (done)
    );

    always #5 CLK = ~CLK;

    // Count done pulses so repeated or missing pulses are visible.
    always @(posedge CLK) begin
        if (done === 1'b1) done_cnt <= done_cnt + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [5:0] n, input logic [7:0] l);
        wr_en   = 1'b1;
        wr_note = n;
        wr_len  = l;
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic hold(input string tag, input logic [15:0] val, input int n);
        for (int i = 0; i < n; i++) begin
            check(tag, {16'd0, note}, {16'd0, val});
            tick();
        end
    endtask

    task automatic wait_note(input string tag, input logic [15:0] val, input int budget);
        int n = 0;
        while (note !== val && n < budget) begin
            tick();
            n++;
        end
        check(tag, {16'd0, note}, {16'd0, val});
    endtask

    initial begin
        repeat (3) @(posedge CLK);
        #1;
        RSTN = 1'b1;
        check("rst_empty", {31'd0, empty}, 32'd1);
        check("rst_full",  {31'd0, full},  32'd0);
        check("rst_note",  {16'd0, note},  32'd0);
        check("rst_busy",  {31'd0, busy},  32'd0);
        check("rst_done",  {31'd0, done},  32'd0);
        tick();

        // Single note {13,3}: 12 cycles of pitch, 4 of gap, then done.
        d0 = done_cnt;
        push(6'd13, 8'd3);
        check("a_empty", {31'd0, empty}, 32'd0);
        check("a_idle_busy", {31'd0, busy}, 32'd0);
        tick();
        check("a_load_busy", {31'd0, busy}, 32'd1);
        check("a_load_note", {16'd0, note}, 32'd0);
        tick();
        hold("a_play", 16'd13, 12);
        hold("a_gap", 16'd0, 4);
        check("a_done", {31'd0, done}, 32'd1);
        check("a_busy_end", {31'd0, busy}, 32'd0);
        tick();
        check("a_done_once", done_cnt, d0 + 1);
        check("a_done_low", {31'd0, done}, 32'd0);

        // Fill the queue while a long note plays; the ninth write is dropped.
        push(6'd20, 8'd10);
        wait_note("b_lead", 16'd20, 10);
        for (int i = 0; i < 9; i++) begin
            wr_en   = 1'b1;
            wr_note = 6'(30 + i);
            wr_len  = 8'd1;
            tick();
            if (i == 6) check("b_not_full7", {31'd0, full}, 32'd0);
            if (i == 7) check("b_full8", {31'd0, full}, 32'd1);
        end
        wr_en = 1'b0;
        check("b_full9", {31'd0, full}, 32'd1);
        d0 = done_cnt;
        for (int i = 0; i < 8; i++) begin
            wait_note("b_order", 16'(30 + i), 60);
            hold("b_len", 16'(30 + i), 4);
            check("b_gap_start", {16'd0, note}, 32'd0);
        end
        hold("b_gap", 16'd0, 4);
        check("b_done", {31'd0, done}, 32'd1);
        check("b_idle", {31'd0, busy}, 32'd0);
        check("b_empty", {31'd0, empty}, 32'd1);
        tick();
        check("b_done_once", done_cnt, d0 + 1);

        // Out-of-range note 60 becomes a two-tick rest.
        push(6'd60, 8'd2);
        tick();
        check("c_load_busy", {31'd0, busy}, 32'd1);
        tick();
        for (int i = 0; i < 12; i++) begin
            check("c_rest_note", {16'd0, note}, 32'd0);
            check("c_rest_busy", {31'd0, busy}, 32'd1);
            tick();
        end
        check("c_done", {31'd0, done}, 32'd1);
        check("c_busy_end", {31'd0, busy}, 32'd0);
        tick();

        // Zero-length entry is skipped straight to the next LOAD.
        push(6'd5, 8'd0);
        push(6'd7, 8'd1);
        tick();
        check("d_load2_note", {16'd0, note}, 32'd0);
        check("d_load2_busy", {31'd0, busy}, 32'd1);
        tick();
        hold("d_play", 16'd7, 4);
        hold("d_gap", 16'd0, 4);
        check("d_done", {31'd0, done}, 32'd1);
        tick();

        // Abort during the first of three notes, with a simultaneous write.
        push(6'd11, 8'd2);
        push(6'd12, 8'd2);
        push(6'd14, 8'd2);
        check("e_play_first", {16'd0, note}, 32'd11);
        d0 = done_cnt;
        abort   = 1'b1;
        wr_en   = 1'b1;
        wr_note = 6'd15;
        wr_len  = 8'd2;
        tick();
        abort = 1'b0;
        wr_en = 1'b0;
        check("e_note",  {16'd0, note},  32'd0);
        check("e_empty", {31'd0, empty}, 32'd1);
        check("e_busy",  {31'd0, busy},  32'd0);
        check("e_done",  {31'd0, done},  32'd0);
        for (int i = 0; i < 30; i++) begin
            check("e_silent", {16'd0, note}, 32'd0);
            check("e_idle", {31'd0, busy}, 32'd0);
            tick();
        end
        check("e_no_done", done_cnt, d0);

        // Asynchronous reset mid-note.
        push(6'd21, 8'd5);
        wait_note("f_play", 16'd21, 10);
        tick();
        #2;
        RSTN = 1'b0;
        #1;
        check("f_async_note",  {16'd0, note},  32'd0);
        check("f_async_busy",  {31'd0, busy},  32'd0);
        check("f_async_empty", {31'd0, empty}, 32'd1);
        tick();
        RSTN = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            check("f_post_note", {16'd0, note}, 32'd0);
            check("f_post_busy", {31'd0, busy}, 32'd0);
            check("f_post_empty", {31'd0, empty}, 32'd1);
        end
        push(6'd22, 8'd1);
        wait_note("f_new", 16'd22, 10);
        hold("f_new_len", 16'd22, 4);
        hold("f_new_gap", 16'd0, 4);
        check("f_new_done", {31'd0, done}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/tone_sequencer.md
TONE_SEQUENCER -- requirements
Module: tone_sequencer

Interface
REQ-001 Parameter DEPTH, default 8, number of queued note entries (power of two).
REQ-002 Parameter TICK_DIV, default 20000, CLK cycles per duration tick (1 ms at 20 MHz).
REQ-003 Parameter GAP_TICKS, default 2, silent ticks inserted after every note.
REQ-004 CLK  input  1  clock.
REQ-005 RSTN  input  1  reset, asynchronous, active-low.
REQ-006 wr_en  input  1  enqueue request, one entry per cycle.
REQ-007 wr_note  input  6  note code; 0 = rest, 1..52 = pitch index.
REQ-008 wr_len  input  8  note duration in ticks.
REQ-009 abort  input  1  flush queue and silence output.
REQ-010 full  output  1  queue holds DEPTH entries.
REQ-011 empty  output  1  queue holds 0 entries.
REQ-012 note  output  16  note code driven to the tone generator; 0 = silent.
REQ-013 busy  output  1  high in any state other than IDLE.
REQ-014 done  output  1  one-cycle pulse when the sequencer returns to IDLE after playing.

Function
REQ-015 Write is accepted when wr_en=1, full=0 and abort=0; a write while full is dropped, with no state change.
REQ-016 full and empty reflect the occupancy registered at the start of the cycle; a write and a pop in the same cycle while full still drops the write.
REQ-017 Each accepted wr_note above 52 is stored as 0 (rest).
REQ-018 The FSM has states IDLE, LOAD, PLAY and GAP.
REQ-019 IDLE: note=0; go to LOAD when empty=0.
REQ-020 LOAD lasts one cycle: pop the head entry and latch the note and length; if length=0, go to LOAD again when empty=0, else to IDLE (no done pulse); otherwise go to PLAY.
REQ-021 PLAY: note={10'b0, latched note} for exactly length*TICK_DIV cycles; the prescaler and tick counter clear on entry.
REQ-022 GAP: note=0 for exactly GAP_TICKS*TICK_DIV cycles, with the prescaler cleared on entry; GAP_TICKS=0 skips GAP.
REQ-023 On leaving GAP (or PLAY when GAP is skipped): go to LOAD if empty=0; otherwise go to IDLE and pulse done in that same cycle.
REQ-024 note is registered and changes in the first cycle of PLAY/GAP/IDLE, with no combinational path from inputs.
REQ-025 Tick counter is 8 bits and the prescaler is clog2(TICK_DIV) bits; neither wraps, since both clear on state entry.
REQ-026 abort has priority over all other events: the next cycle has an empty queue, state IDLE, note=0 and busy=0, with no done pulse.
REQ-027 abort and wr_en in the same cycle: the write is dropped.

Reset
REQ-028 Reset values: state=IDLE, queue empty (empty=1, full=0), note=0, busy=0, done=0, prescaler=0, tick counter=0.
REQ-029 Reset asserted mid-note silences note immediately (asynchronously) and discards all queued entries.

Structure
REQ-030 The shared package holds the FSM state enum, MAX_NOTE=52, NOTE_W=6, LEN_W=8 and OUT_W=16.
REQ-031 The queue is one sub-module, tone_fifo: synchronous, DEPTH entries, 14-bit {note, len} entries, flush input, registered full/empty.
REQ-032 The FSM, prescaler, tick counter and output register stay in tone_sequencer.

Verification (TICK_DIV=4, GAP_TICKS=1)
REQ-033 Write {note=13, len=3} from idle -> LOAD next cycle; note=13 for exactly 12 cycles, then 0 for 4 cycles, then done pulses once; busy returns to 0.
REQ-034 Write 9 entries back-to-back with DEPTH=8 -> full=1 after the 8th write; the 9th is dropped; exactly 8 notes are played in order.
REQ-035 Write {note=60, len=2} -> note output stays 0 for 8 cycles (stored as rest); sequencing still completes with done.
REQ-036 Queue {5,0},{7,1} -> the len-0 entry produces no PLAY cycles; note=7 for 4 cycles.
REQ-037 abort during PLAY of the first of 3 queued notes, with wr_en=1 in the same cycle -> next cycle note=0, empty=1, busy=0, no done; nothing further plays.
REQ-038 RSTN low mid-PLAY -> note=0 asynchronously; after release, state is IDLE with empty=1 and no output until a new write.
